keypad_scan_ctrl: RTL

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

---
 rtl/keypad_scan_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: row strobing, per-key debounce of press and release,
// and a single-entry key register with valid/ready handoff and overrun flag.
module keypad_scan_ctrl #(
   parameter int TICK_DIV     = 1000,
   parameter int STABLE_TICKS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] col_in,
   output logic [3:0] row_out,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ready,
   output logic       overrun,
   input  logic       overrun_clr
);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

   localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);
   localparam logic [3:0]  STABLE_N = 4'(STABLE_TICKS);

   logic [3:0]  r_sync1, r_sync2;
   logic [15:0] r_div;
   state_t      r_state;
   logic [1:0]  r_row_idx, r_col_idx;
   logic [3:0]  r_stable_cnt, r_release_cnt;
   logic [3:0]  r_key_code;
   logic        r_key_valid, r_overrun;

   logic        w_tick, w_any_low, w_cap_low, w_push;
   logic [1:0]  w_low_col;
   logic [3:0]  w_stable_inc, w_release_inc, w_push_code;
   state_t      w_state_next;
   logic [1:0]  w_row_idx_next, w_col_idx_next;
   logic [3:0]  w_stable_next, w_release_next;

   assign w_tick        = (r_div == DIV_LAST);
   assign w_any_low     = ~&r_sync2;
   assign w_cap_low     = ~r_sync2[r_col_idx];
   assign w_stable_inc  = r_stable_cnt + 4'd1;
   assign w_release_inc = r_release_cnt + 4'd1;

   assign row_out   = ~(4'b0001 << r_row_idx);
   assign key_code  = r_key_code;
   assign key_valid = r_key_valid;
   assign overrun   = r_overrun;

   // Lowest-index low column wins when several keys share the active row.
   always_comb begin
      w_low_col = 2'd3;
      if (!r_sync2[0])      w_low_col = 2'd0;
      else if (!r_sync2[1]) w_low_col = 2'd1;
      else if (!r_sync2[2]) w_low_col = 2'd2;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1       <= 4'hF;
         r_sync2       <= 4'hF;
         r_div         <= 16'd0;
         r_state       <= SCAN;
         r_row_idx     <= 2'd0;
         r_col_idx     <= 2'd0;
         r_stable_cnt  <= 4'd0;
         r_release_cnt <= 4'd0;
      end else begin
         r_sync1       <= col_in;
         r_sync2       <= r_sync1;
         r_div         <= w_tick ? 16'd0 : r_div + 16'd1;
         r_state       <= w_state_next;
         r_row_idx     <= w_row_idx_next;
         r_col_idx     <= w_col_idx_next;
         r_stable_cnt  <= w_stable_next;
         r_release_cnt <= w_release_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_row_idx_next = r_row_idx;
      w_col_idx_next = r_col_idx;
      w_stable_next  = r_stable_cnt;
      w_release_next = r_release_cnt;
      w_push         = 1'b0;
      w_push_code    = {r_row_idx, r_col_idx};
      if (w_tick) begin
         case (r_state)
            SCAN: begin
               if (w_any_low) begin
                  w_col_idx_next = w_low_col;
                  w_stable_next  = 4'd1;
                  w_push_code    = {r_row_idx, w_low_col};
                  if (STABLE_N == 4'd1) begin
                     w_push         = 1'b1;
                     w_release_next = 4'd0;
                     w_state_next   = HELD;
                  end else begin
                     w_state_next = DEBOUNCE;
                  end
               end else begin
                  w_row_idx_next = r_row_idx + 2'd1;
               end
            end
            DEBOUNCE: begin
               if (w_cap_low) begin
                  w_stable_next = w_stable_inc;
                  if (w_stable_inc == STABLE_N) begin
                     w_push         = 1'b1;
                     w_release_next = 4'd0;
                     w_state_next   = HELD;
                  end
               end else begin
                  w_row_idx_next = r_row_idx + 2'd1;
                  w_state_next   = SCAN;
               end
            end
            HELD: begin
               if (!w_cap_low) begin
                  if (w_release_inc == STABLE_N) begin
                     w_release_next = 4'd0;
                     w_row_idx_next = r_row_idx + 2'd1;
                     w_state_next   = SCAN;
                  end else begin
                     w_release_next = w_release_inc;
                  end
               end else begin
                  w_release_next = 4'd0;
               end
            end
            default: w_state_next = SCAN;
         endcase
      end
   end

   // A push into a full, unacknowledged register is dropped and flagged;
   // the set beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_key_code  <= 4'd0;
         r_key_valid <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         if (w_push) begin
            if (!r_key_valid || key_ready) begin
               r_key_code  <= w_push_code;
               r_key_valid <= 1'b1;
            end
         end else if (r_key_valid && key_ready) begin
            r_key_valid <= 1'b0;
         end
         if (w_push && r_key_valid && !key_ready) r_overrun <= 1'b1;
         else if (overrun_clr)                    r_overrun <= 1'b0;
      end
   end

endmodule
